// File: rtl/pool_store_layer1.sv
// Layer-1 pooling store: 2x2 max pooling per channel over the quantised window
// vector, then a raster-order write of the pooled word into the feature-map RAM.
// Two-stage pipeline: stage 1 reduces pixel pairs, stage 2 finishes the max and
// issues the RAM write with its position and end-of-frame flag.
module pool_store_layer1 #(
    parameter int unsigned CH        = 32,
    parameter int unsigned DW        = 8,
    parameter int unsigned FMAP_W    = 16,
    parameter int unsigned FMAP_H    = 16,
    parameter int unsigned AW        = 10,
    parameter int unsigned BASE_ADDR = 0,
    localparam int unsigned RW = (FMAP_H > 1) ? $clog2(FMAP_H) : 1,
    localparam int unsigned CW = (FMAP_W > 1) ? $clog2(FMAP_W) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 en_store,
    input  logic [4*CH*DW-1:0]   pool_in,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [CH*DW-1:0]     wr_data,
    output logic [RW-1:0]        row_idx,
    output logic [CW-1:0]        col_idx,
    output logic                 frame_done,
    output logic                 busy
);

    logic [CH-1:0][DW-1:0] s1_a_d, s1_b_d, s1_a_q, s1_b_q, max_d;
    logic                  s1_valid_q;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  last_pos;
    logic [AW-1:0]         addr_d;

    logic                  wr_en_q;
    logic                  frame_done_q;
    logic [AW-1:0]         wr_addr_q;
    logic [CH*DW-1:0]      wr_data_q;
    logic [RW-1:0]         row_idx_q;
    logic [CW-1:0]         col_idx_q;

    // Unsigned pairwise max: (p0,p1) and (p2,p3) for stage 1, then across pairs for stage 2.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            s1_a_d[c] = (pool_in[(4*c+0)*DW +: DW] >= pool_in[(4*c+1)*DW +: DW])
                      ? pool_in[(4*c+0)*DW +: DW] : pool_in[(4*c+1)*DW +: DW];
            s1_b_d[c] = (pool_in[(4*c+2)*DW +: DW] >= pool_in[(4*c+3)*DW +: DW])
                      ? pool_in[(4*c+2)*DW +: DW] : pool_in[(4*c+3)*DW +: DW];
            max_d[c]  = (s1_a_q[c] >= s1_b_q[c]) ? s1_a_q[c] : s1_b_q[c];
        end
    end

    // Raster position advance on each stage-1 handoff, and the matching RAM address.
    always_comb begin
        last_pos = (col_q == CW'(FMAP_W - 1)) && (row_q == RW'(FMAP_H - 1));
        col_d    = col_q;
        row_d    = row_q;
        if (s1_valid_q) begin
            if (col_q == CW'(FMAP_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(FMAP_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        addr_d = AW'(BASE_ADDR) + AW'(row_q) * AW'(FMAP_W) + AW'(col_q);
    end

    // Stage 1: capture pair maxima when a window arrives; clear drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (clear) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= en_store;
            if (en_store) begin
                s1_a_q <= s1_a_d;
                s1_b_q <= s1_b_d;
            end
        end
    end

    // Stage 2: issue the write; data/address/position hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            row_idx_q    <= '0;
            col_idx_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
        end else if (clear) begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
        end else begin
            wr_en_q      <= s1_valid_q;
            frame_done_q <= s1_valid_q && last_pos;
            row_q        <= row_d;
            col_q        <= col_d;
            if (s1_valid_q) begin
                wr_data_q <= max_d;
                wr_addr_q <= addr_d;
                row_idx_q <= row_q;
                col_idx_q <= col_q;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign row_idx    = row_idx_q;
    assign col_idx    = col_idx_q;
    assign busy       = s1_valid_q | wr_en_q;

endmodule

// File: doc/pool_store_layer1.md
Name: pool_store_layer1

Overview:
- Downstream neighbour of the layer-1 bias/quantise/ReLU stage. Consumes its 4×32 byte result vector (4 window pixels × 32 channels) on each `en_store` pulse.
- Performs 2×2 max pooling per channel, producing one 32-channel byte word per pooled position.
- Writes that word to the layer-1 feature-map RAM at a raster-order address, and flags the end of each pooled frame.

Parameters:
- CH, 32, number of channels per word.
- DW, 8, bits per quantised activation.
- FMAP_W, 16, pooled feature-map width (positions per row).
- FMAP_H, 16, pooled feature-map height (rows per frame).
- AW, 10, RAM address width; must satisfy 2^AW >= BASE_ADDR + FMAP_W*FMAP_H.
- BASE_ADDR, 0, RAM address of pooled position (0,0).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart: flush pipeline, zero position counters.
- en_store  input  1  one-cycle valid strobe for pool_in.
- pool_in  input  4*CH*DW  byte i = pool_in[i*8+7:i*8]; channel c = i/4, window pixel p = i%4.
- wr_en  output  1  RAM write strobe.
- wr_addr  output  AW  RAM write address.
- wr_data  output  CH*DW  byte c = pooled max of channel c.
- row_idx  output  $clog2(FMAP_H)  pooled row of the current wr_en word.
- col_idx  output  $clog2(FMAP_W)  pooled column of the current wr_en word.
- frame_done  output  1  one-cycle pulse with the last write of a frame.
- busy  output  1  high while any pipeline stage holds valid data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0: wr_en, wr_addr, wr_data, row_idx, col_idx, frame_done, busy.
  - Pipeline valids and position counters cleared.
- Data is unsigned DW-bit (post-ReLU). Comparisons are unsigned; ties pick either operand (values are equal).
- Stage 1 (registered on en_store):
  - s1_a[c] = max(p0,p1) and s1_b[c] = max(p2,p3) for every channel c.
  - s1_valid <= en_store.
- Stage 2 (registered):
  - wr_data byte c <= max(s1_a[c], s1_b[c]).
  - wr_en <= s1_valid.
  - wr_addr <= BASE_ADDR + row*FMAP_W + col, with row_idx/col_idx taken from the counters.
- Latency: wr_en is high exactly 2 cycles after en_store. Throughput is one window per cycle; back-to-back en_store is fully supported. There is no backpressure, because the upstream stage has none.
- Position counters (col, row) advance only when stage 1 hands off to stage 2:
  - col increments each write.
  - At col == FMAP_W-1, col wraps to 0 and row increments.
  - At row == FMAP_H-1 and col == FMAP_W-1, both wrap to 0.
- frame_done is asserted on the same cycle as that final wr_en. The next frame starts at BASE_ADDR with no idle cycle required.
- wr_data, wr_addr, row_idx and col_idx hold their last values when wr_en is low. Consumers qualify them with wr_en only.
- clear (synchronous, highest priority after reset):
  - Next cycle: s1_valid = 0, wr_en = 0, frame_done = 0, counters = 0.
  - Data in flight is dropped, and an en_store coincident with clear is dropped.
  - en_store on the cycle after clear is accepted normally and written at BASE_ADDR.
- busy = s1_valid | wr_en.
- Asynchronous reset mid-frame: everything returns to reset values immediately. No partial write is issued after rst_n deasserts.
- Widths: the address sum is computed at AW bits; overflow is a parameterisation error and is not handled in RTL.

Test Plan:
- Reset: hold rst_n low 3 cycles with en_store toggling → all outputs 0 throughout; first en_store after release gives wr_en 2 cycles later at wr_addr=BASE_ADDR, row_idx=0, col_idx=0.
- Single window: channel 0 pixels {12,200,7,199}, channel 31 {0,0,0,0}, others {5,5,5,5} → wr_data byte0=200, byte31=0, others=5; wr_en a single one-cycle pulse.
- Unsigned ordering: channel 3 pixels {0x7F,0x80,0x01,0xFF} → byte3=0xFF.
- Full frame, 256 back-to-back en_store (default params) → 256 consecutive wr_en with wr_addr 0..255; col wraps 15→0 with row increment; frame_done high only on addr 255; the 257th input writes addr 0.
- clear mid-pipeline: en_store on cycles 0 and 1, clear on cycle 2 → only the cycle-0 window is written (cycle 2, addr 0); no wr_en on cycle 3; the next en_store writes addr 0.
- Async reset mid-frame: after 37 writes, pulse rst_n low between clock edges → outputs drop to 0 immediately; after release the next window writes addr 0, and frame_done first fires after 256 further writes.
